e_mdu: RTL

E_MDU -- requirements
Module: e_mdu

---
 rtl/e_mdu_pkg.sv | 33 +++
 rtl/e_mdu.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/e_mdu_pkg.sv
// mdu_pkg: opcode encoding, operation latencies and state/write-mode enums
// shared by the multiply/divide unit and anything that drives MDOp.
// Optional accumulate support is selected in e_mdu by MDU_MADD_EN.
package mdu_pkg;

  // MDOp encoding
  localparam logic [3:0] NONE  = 4'd0;
  localparam logic [3:0] MULT  = 4'd1;
  localparam logic [3:0] MULTU = 4'd2;
  localparam logic [3:0] DIV   = 4'd3;
  localparam logic [3:0] DIVU  = 4'd4;
  localparam logic [3:0] MTHI  = 4'd5;
  localparam logic [3:0] MTLO  = 4'd6;
  localparam logic [3:0] MADD  = 4'd7;
  localparam logic [3:0] MADDU = 4'd8;

  // Cycles spent in BUSY per operation class
  localparam logic [3:0] MULT_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT  = 4'd10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  // What happens to HI/LO when the BUSY countdown expires
  typedef enum logic [1:0] {
    WR_NONE = 2'd0,   // discard (divide by zero)
    WR_LOAD = 2'd1,   // HI/LO <= latched result
    WR_ACC  = 2'd2    // {HI,LO} <= {HI,LO} + latched product
  } wr_mode_e;

endpackage

// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit with architectural HI/LO.
// The result is computed combinationally and latched on the start edge; a
// down-counter then models the operation latency, and HI/LO are written
// when it expires. Define MDU_MADD_EN to enable MADD/MADDU accumulation.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no operation pending; accepts start and mthi/mtlo
// BUSY  | counting down latency; HI/LO written on the cnt==1 edge
module e_mdu
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy
);

  mdu_state_e  state;
  mdu_state_e  state_nxt;
  logic [3:0]  cnt;
  logic [31:0] tmp_hi;
  logic [31:0] tmp_lo;
  wr_mode_e    wr_mode;

  logic        op_valid;
  logic [3:0]  op_lat;
  wr_mode_e    op_wr;
  logic [63:0] op_res;

  logic        go;
  logic        mt_go;
  logic        done;

  // Arithmetic operands and results
  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] a_s;
  logic signed [31:0] b_s_safe;
  logic [31:0]        b_u_safe;
  logic               div_zero;
  logic               div_ovf;
  logic [31:0]        quo_s;
  logic [31:0]        rem_s;
  logic [31:0]        quo_u;
  logic [31:0]        rem_u;

  assign a_sx   = {{32{A[31]}}, A};
  assign b_sx   = {{32{B[31]}}, B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, A} * {32'd0, B};

  // The divisor is forced to 1 in the zero and overflow cases so the
  // divider never sees an undefined operation; those results are
  // overridden or discarded below.
  assign div_zero = (B == 32'd0);
  assign div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign a_s      = $signed(A);
  assign b_s_safe = (div_zero || div_ovf) ? 32'sd1 : $signed(B);
  assign b_u_safe = div_zero ? 32'd1 : B;

  // Quotient/remainder; signed division truncates toward zero
  always_comb begin
    quo_u = A / b_u_safe;
    rem_u = A % b_u_safe;
    if (div_ovf) begin
      quo_s = 32'h8000_0000;
      rem_s = 32'd0;
    end else begin
      quo_s = a_s / b_s_safe;
      rem_s = a_s % b_s_safe;
    end
  end

  // Decode MDOp into latency, completion action and the value to latch
  always_comb begin
    op_valid = 1'b0;
    op_lat   = MULT_LAT;
    op_wr    = WR_NONE;
    op_res   = 64'd0;
    case (MDOp)
      MULT: begin
        op_valid = 1'b1;
        op_wr    = WR_LOAD;
        op_res   = prod_s;
      end
      MULTU: begin
        op_valid = 1'b1;
        op_wr    = WR_LOAD;
        op_res   = prod_u;
      end
      DIV: begin
        op_valid = 1'b1;
        op_lat   = DIV_LAT;
        op_wr    = div_zero ? WR_NONE : WR_LOAD;
        op_res   = div_zero ? 64'd0 : {rem_s, quo_s};
      end
      DIVU: begin
        op_valid = 1'b1;
        op_lat   = DIV_LAT;
        op_wr    = div_zero ? WR_NONE : WR_LOAD;
        op_res   = div_zero ? 64'd0 : {rem_u, quo_u};
      end
`ifdef MDU_MADD_EN
      MADD: begin
        op_valid = 1'b1;
        op_wr    = WR_ACC;
        op_res   = prod_s;
      end
      MADDU: begin
        op_valid = 1'b1;
        op_wr    = WR_ACC;
        op_res   = prod_u;
      end
`endif
      default: begin
        op_valid = 1'b0;
      end
    endcase
  end

  // Accept conditions: Req cancels the E-stage instruction, and nothing new
  // is taken while an operation is already in flight.
  assign go    = start && !Req && (state == IDLE) && op_valid;
  assign mt_go = !start && !Req && (state == IDLE) &&
                 ((MDOp == MTHI) || (MDOp == MTLO));
  assign done  = (state == BUSY) && (cnt == 4'd1);
  assign busy  = start || (state == BUSY);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go)   state_nxt = BUSY;
      BUSY:    if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latency down-counter: loaded on start, decremented every BUSY edge
  always_ff @(posedge clk) begin
    if (reset)               cnt <= 4'd0;
    else if (go)             cnt <= op_lat;
    else if (state == BUSY)  cnt <= cnt - 4'd1;
  end

  // Latch the result and the completion action on the start edge
  always_ff @(posedge clk) begin
    if (reset) begin
      tmp_hi  <= 32'd0;
      tmp_lo  <= 32'd0;
      wr_mode <= WR_NONE;
    end else if (go) begin
      tmp_hi  <= op_res[63:32];
      tmp_lo  <= op_res[31:0];
      wr_mode <= op_wr;
    end
  end

  // Architectural HI/LO: written only on completion or mthi/mtlo
  always_ff @(posedge clk) begin
    if (reset) begin
      HI <= 32'd0;
      LO <= 32'd0;
    end else if (done) begin
      case (wr_mode)
        WR_LOAD: begin
          HI <= tmp_hi;
          LO <= tmp_lo;
        end
        WR_ACC:  {HI, LO} <= {HI, LO} + {tmp_hi, tmp_lo};
        default: ;
      endcase
    end else if (mt_go) begin
      if (MDOp == MTHI) HI <= A;
      else              LO <= A;
    end
  end

endmodule
